// File: rtl/prog_mem_loader.sv
// Program ROM port owner: muxes the core flash bus and a FIFO-fed host loader (write/readback).
// Optional PROG_MEM_LOADER_CHECKSUM_EN adds o_checksum, a mod-2^32 sum of transferred words.
module prog_mem_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 8192
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_prog_mode,
    input  logic              i_cmd_write,
    input  logic              i_cmd_read,
    input  logic [ADDR_W:0]   i_word_count,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_empty,
    output logic              o_in_rd_en,
    output logic [DATA_W-1:0] o_out_data,
    input  logic              i_out_full,
    output logic              o_out_wr_en,
    input  logic              i_cpu_men,
    input  logic [31:0]       i_cpu_maddr,
    input  logic [DATA_W-1:0] i_cpu_mdin,
    input  logic [3:0]        i_cpu_mwe,
    output logic [DATA_W-1:0] o_cpu_mdout,
    output logic              o_mem_en,
    output logic [3:0]        o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    input  logic [DATA_W-1:0] i_mem_dout,
    output logic              o_core_resetn,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       o_checksum
`endif
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {StIdle, StWr, StRdIssue, StRdData, StFin} state_e;

    state_e          r_state;
    logic [ADDR_W:0] r_cnt;
    logic [ADDR_W:0] r_wc;
    logic            r_cmd_w;
    logic            r_cmd_r;
    logic            r_src_rd;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_core_resetn;

    logic            w_wr_edge;
    logic            w_rd_edge;
    logic            w_accept;
    logic            w_wr_go;
    logic            w_rd_issue;
    logic            w_rd_push;
    logic [ADDR_W:0] w_cnt_next;
    logic            w_unused;

    assign w_wr_edge  = i_cmd_write & ~r_cmd_w;
    assign w_rd_edge  = i_cmd_read & ~r_cmd_r;
    assign w_accept   = i_prog_mode && (r_state == StIdle) && (w_wr_edge || w_rd_edge);
    // Loader strobes are gated by prog_mode so an abort silences them in the same cycle.
    assign w_wr_go    = i_prog_mode && (r_state == StWr) && !i_in_empty;
    assign w_rd_issue = i_prog_mode && (r_state == StRdIssue) && !i_out_full;
    assign w_rd_push  = i_prog_mode && (r_state == StRdData);
    assign w_cnt_next = r_cnt + ONE_W;
    assign w_unused   = ^{i_cpu_maddr[31:ADDR_W+2], i_cpu_maddr[1:0]};

    always_comb begin
        o_mem_en   = 1'b0;
        o_mem_we   = 4'h0;
        o_mem_addr = r_cnt[ADDR_W-1:0];
        o_mem_din  = i_in_data;
        if (!i_prog_mode) begin
            o_mem_en   = i_cpu_men;
            o_mem_we   = i_cpu_mwe;
            o_mem_addr = i_cpu_maddr[ADDR_W+1:2];
            o_mem_din  = i_cpu_mdin;
        end else begin
            o_mem_en   = w_wr_go | w_rd_issue;
            o_mem_we   = w_wr_go ? 4'hF : 4'h0;
        end
    end

    assign o_cpu_mdout   = i_mem_dout;
    assign o_out_data    = i_mem_dout;
    assign o_in_rd_en    = w_wr_go;
    assign o_out_wr_en   = w_rd_push;
    assign o_core_resetn = r_core_resetn;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_wc          <= '0;
            r_cmd_w       <= 1'b0;
            r_cmd_r       <= 1'b0;
            r_src_rd      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_core_resetn <= 1'b0;
        end else begin
            r_cmd_w       <= i_cmd_write;
            r_cmd_r       <= i_cmd_read;
            // With prog_mode low the next state is always idle, so this tracks the idle condition.
            r_core_resetn <= ~i_prog_mode;
            if (r_done && !(r_src_rd ? i_cmd_read : i_cmd_write)) begin
                r_done <= 1'b0;
            end
            if (!i_prog_mode) begin
                if (r_state != StIdle) begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_accept) begin
                            r_src_rd <= ~w_wr_edge;
                            r_cnt    <= '0;
                            r_wc     <= i_word_count;
                            r_done   <= 1'b0;
                            r_err    <= 1'b0;
                            if (i_word_count > DEPTH_W) begin
                                r_err   <= 1'b1;
                                r_state <= StFin;
                            end else if (i_word_count == '0) begin
                                r_state <= StFin;
                            end else begin
                                r_busy  <= 1'b1;
                                r_state <= w_wr_edge ? StWr : StRdIssue;
                            end
                        end
                    end
                    StWr: begin
                        if (!i_in_empty) begin
                            r_cnt <= w_cnt_next;
                            if (w_cnt_next == r_wc) r_state <= StFin;
                        end
                    end
                    StRdIssue: begin
                        if (!i_out_full) r_state <= StRdData;
                    end
                    StRdData: begin
                        r_cnt   <= w_cnt_next;
                        r_state <= (w_cnt_next == r_wc) ? StFin : StRdIssue;
                    end
                    StFin: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_wr_go) begin
            r_checksum <= r_checksum + 32'(i_in_data);
        end else if (w_rd_push) begin
            r_checksum <= r_checksum + 32'(i_mem_dout);
        end
    end

    assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: ROM and FIFO models plus a per-cycle transfer model.
// Checksum checks are active when PROG_MEM_LOADER_CHECKSUM_EN is defined.
module tb_prog_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_mode, cmd_write, cmd_read;
    logic [13:0] word_count;
    logic [31:0] in_data;
    logic        in_empty, in_rd_en;
    logic [31:0] out_data;
    logic        out_full, out_wr_en;
    logic        cpu_men;
    logic [31:0] cpu_maddr, cpu_mdin, cpu_mdout;
    logic [3:0]  cpu_mwe;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic        core_resetn, busy, done, err;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    prog_mem_loader dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_prog_mode(prog_mode),
        .i_cmd_write(cmd_write), .i_cmd_read(cmd_read), .i_word_count(word_count),
        .i_in_data(in_data), .i_in_empty(in_empty), .o_in_rd_en(in_rd_en),
        .o_out_data(out_data), .i_out_full(out_full), .o_out_wr_en(out_wr_en),
        .i_cpu_men(cpu_men), .i_cpu_maddr(cpu_maddr), .i_cpu_mdin(cpu_mdin),
        .i_cpu_mwe(cpu_mwe), .o_cpu_mdout(cpu_mdout),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout), .o_core_resetn(core_resetn),
        .o_busy(busy), .o_done(done), .o_err(err)
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        , .o_checksum(checksum)
`endif
    );

    // ROM with byte enables and 1-cycle read latency
    logic [31:0] rom [0:8191];
    int          en_count = 0;
    always @(posedge clk) begin
        if (mem_en) begin
            en_count <= en_count + 1;
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) rom[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            mem_dout <= rom[mem_addr];
        end
    end

    // Pipe-in FWFT FIFO: the bench fills in_mem and advances in_wp; DUT pops advance in_rp
    logic [31:0] in_mem [0:31];
    int          in_wp = 0;
    int          in_rp = 0;
    assign in_empty = (in_rp == in_wp);
    assign in_data  = in_mem[in_rp % 32];
    always @(posedge clk) if (in_rd_en) in_rp <= in_rp + 1;

    logic [31:0] out_got [0:31];
    int          out_cnt = 0;
    always @(posedge clk) begin
        if (out_wr_en) begin
            out_got[out_cnt % 32] <= out_data;
            out_cnt <= out_cnt + 1;
        end
    end

    // Transfer model: allowed word counts and expected images for the current command
    logic [31:0] exp_img [0:31];
    logic [31:0] exp_rd  [0:31];
    int wr_seen = 0, wr_lo = 0, wr_n = 0;
    int rd_iss = 0, rd_lo_i = 0, rd_push = 0, rd_lo_p = 0, rd_n = 0;
    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycle_check();
        int idx;
        if (!rst_n) return;
        if (!prog_mode) begin
            chk("core mux en", mem_en, cpu_men);
            chk("core mux we", mem_we, cpu_mwe);
            chk("core mux addr", mem_addr, cpu_maddr[14:2]);
            chk("core mux din", mem_din, cpu_mdin);
            chk("core mux dout", cpu_mdout, mem_dout);
            chk("core mode pop", in_rd_en, 0);
            chk("core mode push", out_wr_en, 0);
        end else begin
            if (mem_en && mem_we == 4'hF) begin
                idx = wr_seen - wr_lo;
                chk("write allowed", idx < wr_n, 1);
                chk("write pops", in_rd_en, 1);
                chk("write not empty", in_empty, 0);
                chk("write addr", mem_addr, 32'(idx));
                chk("write data", mem_din, exp_img[idx % 32]);
                wr_seen++;
            end else if (mem_en) begin
                idx = rd_iss - rd_lo_i;
                chk("issue allowed", idx < rd_n, 1);
                chk("issue we", mem_we, 0);
                chk("issue addr", mem_addr, 32'(idx));
                chk("issue not full", out_full, 0);
                rd_iss++;
            end else begin
                chk("no pop without write", in_rd_en, 0);
            end
            if (out_wr_en) begin
                idx = rd_push - rd_lo_p;
                chk("push allowed", idx < rd_n, 1);
                chk("push not full", out_full, 0);
                chk("push data", out_data, exp_rd[idx % 32]);
                rd_push++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, done, 1);
    endtask

    task automatic new_cmd(input int nw, input int nr);
        wr_lo = wr_seen; wr_n = nw;
        rd_lo_i = rd_iss; rd_lo_p = rd_push; rd_n = nr;
    endtask

    initial begin
        int n, base, e0, ob;
        rst_n = 0; prog_mode = 0; cmd_write = 0; cmd_read = 0; word_count = 0; out_full = 0;
        cpu_men = 0; cpu_maddr = 0; cpu_mdin = 0; cpu_mwe = 0;
        step(); step();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset core_resetn", core_resetn, 0);
        chk("reset in_rd_en", in_rd_en, 0);
        chk("reset out_wr_en", out_wr_en, 0);
        rst_n = 1;
        step();
        chk("core released", core_resetn, 1);

        // Core owns the ROM: write then read byte address 0x10
        cpu_men = 1; cpu_maddr = 32'h10; cpu_mdin = 32'hCAFE_0004; cpu_mwe = 4'hF;
        step();
        chk("core addr 0x10", mem_addr, 32'd4);
        chk("core we", mem_we, 32'hF);
        cpu_mwe = 0;
        step();
        chk("core readback", cpu_mdout, 32'hCAFE_0004);
        cpu_men = 0;

        // WRITE of 4 words with one stall cycle after word 2
        prog_mode = 1;
        step();
        chk("core held in reset", core_resetn, 0);
        base = in_wp;
        for (int i = 0; i < 4; i++) begin
            in_mem[(base + i) % 32] = 32'(i + 1);
            exp_img[i] = 32'(i + 1);
        end
        in_wp = base + 2;
        new_cmd(4, 0);
        e0 = en_count;
        word_count = 4; cmd_write = 1;
        step();
        chk("busy in write", busy, 1);
        n = 0;
        while (in_rp != base + 2 && n < 20) begin step(); n++; end
        chk("two words popped", in_rp - base, 2);
        n = en_count;
        step();
        chk("no strobe in stall", en_count - n, 0);
        in_wp = base + 4;
        wait_done("write done", 30);
        for (int i = 0; i < 4; i++) chk("rom image", rom[i], 32'(i + 1));
        chk("write strobes", en_count - e0, 4);
        chk("write err", err, 0);
        chk("write busy cleared", busy, 0);
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        chk("write checksum", checksum, 32'd10);
`endif
        cmd_write = 0;
        step();
        chk("write done cleared", done, 0);

        // READBACK of 4 words, FIFO full for 3 cycles after word 1
        for (int i = 0; i < 4; i++) exp_rd[i] = 32'(i + 1);
        new_cmd(0, 4);
        ob = out_cnt;
        word_count = 4; cmd_read = 1;
        n = 0;
        while (out_cnt != ob + 1 && n < 20) begin step(); n++; end
        out_full = 1;
        e0 = en_count;
        repeat (3) step();
        chk("no issue while full", en_count - e0, 0);
        chk("no push while full", out_cnt - ob, 1);
        out_full = 0;
        wait_done("read done", 30);
        chk("read words pushed", out_cnt - ob, 4);
        for (int i = 0; i < 4; i++) chk("read order", out_got[(ob + i) % 32], 32'(i + 1));
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        chk("read checksum", checksum, 32'd10);
`endif
        cmd_read = 0;
        step();
        chk("read done cleared", done, 0);

        // Oversize count rejected, then zero-length read
        new_cmd(0, 0);
        e0 = en_count;
        word_count = 14'd8193; cmd_write = 1;
        step();
        chk("oversize err", err, 1);
        wait_done("oversize done", 10);
        chk("oversize no access", en_count - e0, 0);
        chk("oversize busy", busy, 0);
        cmd_write = 0;
        step();
        chk("oversize done cleared", done, 0);
        chk("err held", err, 1);
        word_count = 0; cmd_read = 1;
        wait_done("zero done", 10);
        chk("zero err", err, 0);
        chk("zero no access", en_count - e0, 0);
        cmd_read = 0;
        step();

        // Simultaneous edges: write wins
        base = in_wp;
        in_mem[base % 32] = 32'hA; in_mem[(base + 1) % 32] = 32'hB;
        exp_img[0] = 32'hA; exp_img[1] = 32'hB;
        in_wp = base + 2;
        new_cmd(2, 0);
        ob = out_cnt;
        word_count = 2; cmd_write = 1; cmd_read = 1;
        wait_done("both done", 20);
        chk("both rom0", rom[0], 32'hA);
        chk("both rom1", rom[1], 32'hB);
        chk("both no readback", out_cnt - ob, 0);
        cmd_write = 0;
        step();
        chk("both done follows write", done, 0);
        cmd_read = 0;
        step();

        // Abort by dropping prog_mode after word 2 of 4
        base = in_rp;
        for (int i = 0; i < 4; i++) begin
            in_mem[(in_wp + i) % 32] = 32'h11 + 32'(i);
            exp_img[i] = 32'h11 + 32'(i);
        end
        in_wp = in_wp + 4;
        new_cmd(2, 0);
        word_count = 4; cmd_write = 1;
        n = 0;
        while (in_rp != base + 2 && n < 20) begin step(); n++; end
        prog_mode = 0;
        e0 = en_count;
        step();
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort core_resetn", core_resetn, 1);
        chk("abort pops", in_rp - base, 2);
        prog_mode = 1;
        step(); step();
        chk("abort stays idle", en_count - e0, 0);
        chk("abort no more pops", in_rp - base, 2);
        chk("abort rom0", rom[0], 32'h11);
        chk("abort rom1", rom[1], 32'h12);
        chk("abort rom2 kept", rom[2], 32'd3);
        cmd_write = 0;
        step();

        // Reset in the middle of a write
        base = in_rp;
        exp_img[0] = 32'h13; exp_img[1] = 32'h14; exp_img[2] = 32'h21; exp_img[3] = 32'h22;
        in_mem[in_wp % 32] = 32'h21; in_mem[(in_wp + 1) % 32] = 32'h22;
        in_wp = in_wp + 2;
        new_cmd(4, 0);
        word_count = 4; cmd_write = 1;
        n = 0;
        while (in_rp != base + 1 && n < 20) begin step(); n++; end
        rst_n = 0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst err", err, 0);
        chk("midrst core_resetn", core_resetn, 0);
        chk("midrst in_rd_en", in_rd_en, 0);
        chk("midrst out_wr_en", out_wr_en, 0);
        chk("midrst mem_en", mem_en, 0);
        cmd_write = 0;
        step();
        rst_n = 1;
        e0 = en_count;
        step(); step();
        chk("post reset idle", en_count - e0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
